// File: rtl/mu0_pkg.sv
// MU0 shared definitions: FSM states, opcodes and ALU function codes.
// Imported by the MU0 control unit and its decoder.
package mu0_pkg;

  localparam int OPW = 4;
  localparam int FSW = 2;

  typedef enum logic [1:0] {
    S_FETCH = 2'b00,
    S_EXEC  = 2'b01,
    S_HALT  = 2'b10
  } state_t;

  localparam logic [OPW-1:0] OP_LDA = 4'd0;
  localparam logic [OPW-1:0] OP_STO = 4'd1;
  localparam logic [OPW-1:0] OP_ADD = 4'd2;
  localparam logic [OPW-1:0] OP_SUB = 4'd3;
  localparam logic [OPW-1:0] OP_JMP = 4'd4;
  localparam logic [OPW-1:0] OP_JGE = 4'd5;
  localparam logic [OPW-1:0] OP_JNE = 4'd6;
  localparam logic [OPW-1:0] OP_STP = 4'd7;

  localparam logic [FSW-1:0] FS_B   = 2'b00;
  localparam logic [FSW-1:0] FS_ADD = 2'b01;
  localparam logic [FSW-1:0] FS_INC = 2'b10;
  localparam logic [FSW-1:0] FS_SUB = 2'b11;

endpackage

// File: rtl/mu0_decode.sv
// MU0 control decode: state, opcode, flags and memory ready
// to datapath controls and next state. Purely combinational.
module mu0_decode
  import mu0_pkg::*;
(
  input  state_t         st,
  input  logic [OPW-1:0] f,
  input  logic           n,
  input  logic           z,
  input  logic           rdy,
  output state_t         nxt,
  output logic           x_sel,
  output logic           y_sel,
  output logic           addr_sel,
  output logic           pc_en,
  output logic           ir_en,
  output logic           acc_en,
  output logic [FSW-1:0] alu_fs,
  output logic           mem_rd,
  output logic           mem_wr,
  output logic           halted
);

  always_comb begin
    nxt      = st;
    x_sel    = 1'b0;
    y_sel    = 1'b0;
    addr_sel = 1'b0;
    pc_en    = 1'b0;
    ir_en    = 1'b0;
    acc_en   = 1'b0;
    alu_fs   = FS_B;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    halted   = 1'b0;
    unique case (1'b1)
      (st == S_FETCH): begin
        mem_rd = 1'b1;
        x_sel  = 1'b1;
        alu_fs = FS_INC;
        ir_en  = rdy;
        pc_en  = rdy;
        nxt    = rdy ? S_EXEC : S_FETCH;
      end
      (st == S_EXEC): begin
        nxt = S_FETCH;
        unique case (f)
          OP_LDA: begin
            addr_sel = 1'b1;
            mem_rd   = 1'b1;
            acc_en   = rdy;
            nxt      = rdy ? S_FETCH : S_EXEC;
          end
          OP_STO: begin
            addr_sel = 1'b1;
            mem_wr   = 1'b1;
            nxt      = rdy ? S_FETCH : S_EXEC;
          end
          OP_ADD, OP_SUB: begin
            addr_sel = 1'b1;
            mem_rd   = 1'b1;
            alu_fs   = (f == OP_ADD) ? FS_ADD : FS_SUB;
            acc_en   = rdy;
            nxt      = rdy ? S_FETCH : S_EXEC;
          end
          OP_JMP: begin
            y_sel = 1'b1;
            pc_en = 1'b1;
          end
          OP_JGE: begin
            y_sel = 1'b1;
            pc_en = ~n;
          end
          OP_JNE: begin
            y_sel = 1'b1;
            pc_en = ~z;
          end
          OP_STP: nxt = S_HALT;
          default: nxt = S_FETCH;
        endcase
      end
      (st == S_HALT): halted = 1'b1;
      default: nxt = S_FETCH;
    endcase
  end

endmodule

// File: rtl/mu0_control.sv
// MU0 control unit: state register, reset gating of all
// controls, and the combinational decoder.
module mu0_control
  import mu0_pkg::*;
(
  input  logic           Clk,
  input  logic           Reset,
  input  logic [OPW-1:0] F,
  input  logic           N,
  input  logic           Z,
  input  logic           Mem_Rdy,
  output logic           X_sel,
  output logic           Y_sel,
  output logic           Addr_sel,
  output logic           PC_En,
  output logic           IR_En,
  output logic           Acc_En,
  output logic [FSW-1:0] ALU_fs,
  output logic           MEM_rd,
  output logic           MEM_wr,
  output logic           Halted
);

  state_t         st;
  state_t         nxt;
  logic           d_x;
  logic           d_y;
  logic           d_addr;
  logic           d_pc;
  logic           d_ir;
  logic           d_acc;
  logic [FSW-1:0] d_fs;
  logic           d_rd;
  logic           d_wr;
  logic           d_halt;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) st <= S_FETCH;
    else        st <= nxt;
  end

  mu0_decode u_dec (
    .st       (st),
    .f        (F),
    .n        (N),
    .z        (Z),
    .rdy      (Mem_Rdy),
    .nxt      (nxt),
    .x_sel    (d_x),
    .y_sel    (d_y),
    .addr_sel (d_addr),
    .pc_en    (d_pc),
    .ir_en    (d_ir),
    .acc_en   (d_acc),
    .alu_fs   (d_fs),
    .mem_rd   (d_rd),
    .mem_wr   (d_wr),
    .halted   (d_halt)
  );

  // reset low kills every control immediately, even mid-stall
  assign X_sel    = d_x    & Reset;
  assign Y_sel    = d_y    & Reset;
  assign Addr_sel = d_addr & Reset;
  assign PC_En    = d_pc   & Reset;
  assign IR_En    = d_ir   & Reset;
  assign Acc_En   = d_acc  & Reset;
  assign ALU_fs   = d_fs   & {FSW{Reset}};
  assign MEM_rd   = d_rd   & Reset;
  assign MEM_wr   = d_wr   & Reset;
  assign Halted   = d_halt & Reset;

endmodule
